// File: rtl/scoreboard_bcd.sv
// Two-player BCD score keeper and digit-render sequencer.
// Feeds digit/yofs to a 5x5 glyph ROM, takes back the row and registers one score pixel.
// Build option: define SCORE_FRAME_LATCH_EN to show scores latched once per frame.
module scoreboard_bcd #(
    parameter logic [8:0] X0 = 9'd32,
    parameter logic [8:0] X1 = 9'd192,
    parameter logic [8:0] Y0 = 9'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       display_on,
    input  logic       inc0,
    input  logic       inc1,
    input  logic       clear_scores,
    input  logic [4:0] digit_bits,
    output logic [3:0] digit,
    output logic [2:0] yofs,
    output logic       score_pixel,
    output logic [7:0] score0,
    output logic [7:0] score1,
    output logic       ovf0,
    output logic       ovf1
);

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [7:0] r;
        if (s[3:0] != 4'd9) begin
            r = {s[7:4], s[3:0] + 4'd1};
        end else if (s[7:4] != 4'd9) begin
            r = {s[7:4] + 4'd1, 4'd0};
        end else begin
            r = 8'h00;
        end
        return r;
    endfunction

    logic [7:0] score0_q, score1_q;
    logic       ovf0_q, ovf1_q;
    logic [7:0] src0, src1;

    logic [3:0] digit_q, digit_d;
    logic [2:0] yofs_q, yofs_d;
    logic [2:0] xofs_q, xofs_d;
    logic       in_glyph_q, in_glyph_d;
    logic       score_pixel_q;

    // Score counters; clear beats increment, ovf pulses only on the 99 -> 00 wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score0_q <= 8'h00;
            score1_q <= 8'h00;
            ovf0_q   <= 1'b0;
            ovf1_q   <= 1'b0;
        end else if (clear_scores) begin
            score0_q <= 8'h00;
            score1_q <= 8'h00;
            ovf0_q   <= 1'b0;
            ovf1_q   <= 1'b0;
        end else begin
            ovf0_q <= inc0 && (score0_q == 8'h99);
            ovf1_q <= inc1 && (score1_q == 8'h99);
            if (inc0) score0_q <= bcd_inc(score0_q);
            if (inc1) score1_q <= bcd_inc(score1_q);
        end
    end

`ifdef SCORE_FRAME_LATCH_EN
    logic [7:0] disp0_q, disp1_q;

    // Frame shadows: snapshot the live scores at the top-left beam position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp0_q <= 8'h00;
            disp1_q <= 8'h00;
        end else if (hpos == 9'd0 && vpos == 9'd0) begin
            disp0_q <= score0_q;
            disp1_q <= score1_q;
        end
    end

    assign src0 = disp0_q;
    assign src1 = disp1_q;
`else
    assign src0 = score0_q;
    assign src1 = score1_q;
`endif

    // Field geometry. Only the low bits of the offsets matter once in-field is known.
    logic [4:0] rel0, rel1;
    logic [3:0] vrel;
    logic [2:0] row, xofs0, xofs1;
    logic       in_rows, in_f0, in_f1;

    assign rel0    = hpos[4:0] - X0[4:0];
    assign rel1    = hpos[4:0] - X1[4:0];
    assign vrel    = vpos[3:0] - Y0[3:0];
    assign row     = 3'(vrel >> 1);
    assign xofs0   = 3'(rel0 >> 1);
    assign xofs1   = 3'(rel1 >> 1);
    assign in_rows = (vpos >= Y0) && ({1'b0, vpos} < ({1'b0, Y0} + 10'd10));
    assign in_f0   = display_on && in_rows && (hpos >= X0)
                     && ({1'b0, hpos} < ({1'b0, X0} + 10'd32));
    assign in_f1   = display_on && in_rows && (hpos >= X1)
                     && ({1'b0, hpos} < ({1'b0, X1} + 10'd32));

    // Stage-1 next state: pick the digit under the beam; field 0 wins on overlap.
    always_comb begin
        digit_d    = 4'd15;
        yofs_d     = 3'd0;
        xofs_d     = 3'd0;
        in_glyph_d = 1'b0;
        if (in_f0) begin
            digit_d    = rel0[4] ? src0[3:0] : src0[7:4];
            yofs_d     = row;
            xofs_d     = xofs0;
            in_glyph_d = (xofs0 <= 3'd4);
        end else if (in_f1) begin
            digit_d    = rel1[4] ? src1[3:0] : src1[7:4];
            yofs_d     = row;
            xofs_d     = xofs1;
            in_glyph_d = (xofs1 <= 3'd4);
        end
    end

    // Stage 1: ROM address and column bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q    <= 4'd15;
            yofs_q     <= 3'd0;
            xofs_q     <= 3'd0;
            in_glyph_q <= 1'b0;
        end else begin
            digit_q    <= digit_d;
            yofs_q     <= yofs_d;
            xofs_q     <= xofs_d;
            in_glyph_q <= in_glyph_d;
        end
    end

    // Column 0 of the glyph is the MSB of the ROM row; shifting lines it up at bit 4.
    logic [4:0] bits_sh;
    assign bits_sh = digit_bits << xofs_q;

    // Stage 2: registered pixel from the ROM row returned during stage 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_pixel_q <= 1'b0;
        end else begin
            score_pixel_q <= in_glyph_q && bits_sh[4];
        end
    end

    assign digit       = digit_q;
    assign yofs        = yofs_q;
    assign score_pixel = score_pixel_q;
    assign score0      = score0_q;
    assign score1      = score1_q;
    assign ovf0        = ovf0_q;
    assign ovf1        = ovf1_q;

endmodule
